// File: rtl/rf_pkg.sv
// Shared register-file constants and helpers for the 8x16b register file and its
// write-back users.
package rf_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned DATA_W   = 16;

  typedef logic [SEL_W-1:0]    reg_sel_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  function automatic reg_mask_t sel_mask(input reg_sel_t sel);
    reg_mask_t m;
    m      = '0;
    m[sel] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-input round-robin arbiter. The pointer holds the last granted index and only
// moves on a cycle that actually grants.
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = ptr_q ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
    ptr_d = ptr_q;
    if (gnt != 2'b00) begin
      ptr_d = gnt[1];
    end
  end

  // Pointer resets to 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back controller: shares the register file write port between the ALU and the
// load path, tracks registers with a pending write-back and flags protocol errors.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_en,
  input  logic [SEL_W-1:0]    rsv_sel,
  input  logic                req0_valid,
  input  logic [SEL_W-1:0]    req0_sel,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  input  logic [SEL_W-1:0]    req1_sel,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                gnt0,
  output logic                gnt1,
  output logic                wr_en,
  output logic [SEL_W-1:0]    wr_sel,
  output logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  logic [1:0] gnt;
  reg_mask_t  busy_q, busy_d, clr_mask, set_mask;
  reg_sel_t   wr_sel_q;
  reg_data_t  wr_data_q;
  logic       wr_en_q, err_q, prot_err;

  rr_arb_2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  always_comb begin
    clr_mask = '0;
    if (gnt[0]) begin
      clr_mask = sel_mask(req0_sel);
    end else if (gnt[1]) begin
      clr_mask = sel_mask(req1_sel);
    end
    set_mask = rsv_en ? sel_mask(rsv_sel) : '0;
    // Set after clear: a same-cycle re-reserve of the written register keeps it busy.
    busy_d   = (busy_q & ~clr_mask) | set_mask;

    prot_err = 1'b0;
    if (req0_valid && !busy_q[req0_sel] && !(rsv_en && rsv_sel == req0_sel)) prot_err = 1'b1;
    if (req1_valid && !busy_q[req1_sel] && !(rsv_en && rsv_sel == req1_sel)) prot_err = 1'b1;
    if (req0_valid && req1_valid && req0_sel == req1_sel) prot_err = 1'b1;
    if (rsv_en && busy_q[rsv_sel] && !clr_mask[rsv_sel]) prot_err = 1'b1;
    if (req0_valid && $isunknown(req0_sel)) prot_err = 1'b1;
    if (req1_valid && $isunknown(req1_sel)) prot_err = 1'b1;
    if (rsv_en && $isunknown(rsv_sel)) prot_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= |gnt;
      if (gnt[0]) begin
        wr_sel_q  <= req0_sel;
        wr_data_q <= req0_data;
      end else if (gnt[1]) begin
        wr_sel_q  <= req1_sel;
        wr_data_q <= req1_data;
      end
      busy_q <= busy_d;
      err_q  <= err_q | prot_err;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back controller for the 8x16b register file. It shares the register file's single write port between two write-back requesters (port 0: ALU, port 1: memory/load) using round-robin arbitration. It also keeps a busy scoreboard of registers with a write-back pending. It sits between the pipeline write-back sources and the register file write inputs (writeRegSel/writeData/writeEn).

Parameters:
NUM_REGS, 8, number of architectural registers; fixed by the 3-bit select.
SEL_W, 3, register select width.
DATA_W, 16, write data width.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
rsv_en  in  1  reserve a destination register (issue marks it pending)
rsv_sel  in  3  register to reserve
req0_valid  in  1  requester 0 has write-back data
req0_sel  in  3  requester 0 destination register
req0_data  in  16  requester 0 write data
req1_valid  in  1  requester 1 has write-back data
req1_sel  in  3  requester 1 destination register
req1_data  in  16  requester 1 write data
gnt0  out  1  combinational accept of requester 0 this cycle
gnt1  out  1  combinational accept of requester 1 this cycle
wr_en  out  1  register file writeEn (registered)
wr_sel  out  3  register file writeRegSel (registered)
wr_data  out  16  register file writeData (registered)
busy  out  8  scoreboard: bit i = register i has a pending write-back
err  out  1  protocol error, registered, sticky until rst

Behaviour:
- Reset (rst=1 at a clk edge): wr_en=0, wr_sel=0, wr_data=0, busy=8'h00, err=0, last-grant pointer=1, so requester 0 wins the first conflict.
- Arbitration (combinational):
  - Only req0_valid: gnt0=1.
  - Only req1_valid: gnt1=1.
  - Both valid: grant the requester that is not the last-grant pointer.
  - Neither valid: no grant.
  - At most one gnt is high per cycle. gnt is low while rst=1.
- Pointer updates only on a cycle with a grant, to the granted index. Idle cycles keep it.
- A requester not granted must hold valid/sel/data stable until granted. The block does not buffer.
- Write path: one-cycle latency. On a grant at edge N, wr_en=1, wr_sel and wr_data take the winner's values after edge N and are visible during cycle N+1. With no grant, wr_en=0 after the edge; wr_sel/wr_data hold their last values.
- Scoreboard, evaluated at each edge:
  - A grant clears busy[granted sel].
  - rsv_en sets busy[rsv_sel].
  - If both hit the same register in the same cycle, set wins and busy stays 1. This is the back-to-back reuse of a destination register.
- Sustained conflict: strict alternation 0,1,0,1... starting with 0 after reset.
- err is set (and held) when any of these holds at an edge:
  - req0_valid or req1_valid with a sel that is not busy and not being reserved that same cycle (write-back without reservation).
  - req0_valid and req1_valid with equal sel.
  - rsv_en to a register already busy and not being cleared by a grant that same cycle.
  - Any sel input that is X/Z while its valid/enable is high.
- The offending operation is still performed as specified above. err is diagnostic only.
- Reset mid-operation: pending scoreboard entries are discarded, no write is issued after the reset edge, and the pointer returns to 1.

Decomposition:
- Shared package rf_pkg: NUM_REGS, SEL_W, DATA_W constants. Reused by the register file and other write-back users.
- One sub-module, rr_arb_2: 2-input round-robin arbiter with the pointer flop. Inputs: clk, rst, req[1:0]. Output: gnt[1:0].
- Scoreboard, write-port flops and error logic stay in rf_wb_arbiter.

Test Plan:
- Reset, then rsv_en sel=3, then req0_valid sel=3 data=16'hBEEF -> gnt0=1 the same cycle; next cycle wr_en=1, wr_sel=3, wr_data=16'hBEEF; busy: 8'h08 after the reserve, 8'h00 after the grant; err=0.
- Reserve regs 1 and 2; req0 (sel=1, 16'h1111) and req1 (sel=2, 16'h2222) both valid -> gnt0 first; 16'h1111 is written, then 16'h2222 the following cycle; busy: 8'h06 -> 8'h04 -> 8'h00.
- Hold both requesters valid for 6 cycles (re-reserving each register as granted) -> grant order 0,1,0,1,0,1; wr_en=1 every cycle after the first.
- Same cycle: grant clears reg 5 and rsv_en sel=5 -> busy[5] stays 1, err=0; a second write-back to reg 5 then clears it.
- Error cases, each after a reset:
  - req1_valid sel=6 with busy=0 -> err=1 next cycle, stays 1.
  - Both valid with sel=4 -> err=1.
  - rsv_en sel=7 twice with no write-back -> err=1.
- Assert rst while busy=8'hFF and both requesters valid -> next cycle busy=0, wr_en=0, err=0; a subsequent conflict grants requester 0 first.
